// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory: load/store codes, FSM states,
// request bit positions and the store byte-lane helper.
package dmem_pkg;

  localparam int RD_REQ = 3;
  localparam int WR_REQ = 2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACCESS = 2'd1;
  localparam state_t S_DONE   = 2'd2;

  // Byte enables; the reserved size writes nothing.
  function automatic logic [3:0] store_be(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_memory_load_align.sv
// Load result formatting: picks the byte/halfword out of a word
// and sign- or zero-extends it according to funct3.
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   result = {{24{b[7]}}, b};
      F3_LH:   result = {{16{h[15]}}, h};
      F3_LW:   result = word;
      F3_LBU:  result = {24'b0, b};
      F3_LHU:  result = {16'b0, h};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Multi-cycle data memory: latches one request in IDLE, spends
// LATENCY cycles in ACCESS, commits on entry to DONE.
module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  read,
  input  logic [2:0]  write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busywait
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  logic          req_rd;
  logic          req_wr;
  logic [2:0]    req_f3;
  logic [1:0]    req_sz;
  logic [AW-1:0] req_idx;
  logic [1:0]    req_off;
  logic [31:0]   req_wdata;

  logic [31:0]   mem [DEPTH];

  logic          start;
  logic          commit;
  logic [3:0]    be;
  logic [31:0]   lanes;
  logic [31:0]   word;
  logic [31:0]   ld;
  logic          unused_addr;

  assign unused_addr = ^addr[31:AW+2];

  assign start  = (state == S_IDLE)
                & (read[RD_REQ] | write[WR_REQ]);
  assign commit = (state == S_ACCESS) & (cnt == LAST);

  // Reset wins over a request seen in IDLE.
  assign busywait = ~reset
                  & (start | (state == S_ACCESS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ACCESS;
            cnt       <= '0;
            req_rd    <= read[RD_REQ];
            req_f3    <= read[2:0];
            req_wr    <= write[WR_REQ];
            req_sz    <= write[1:0];
            req_idx   <= addr[AW+1:2];
            req_off   <= addr[1:0];
            req_wdata <= write_data;
          end
        end
        S_ACCESS: begin
          if (commit) state <= S_DONE;
          else        cnt   <= cnt + 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign be   = store_be(req_sz, req_off);
  assign word = mem[req_idx];

  always_comb begin
    case (req_sz)
      SZ_B:    lanes = {4{req_wdata[7:0]}};
      SZ_H:    lanes = {2{req_wdata[15:0]}};
      default: lanes = req_wdata;
    endcase
  end

  // Contents survive reset; an aborted store never lands.
  always_ff @(posedge clk) begin
    if (commit && req_wr && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[req_idx][8*i +: 8] <= lanes[8*i +: 8];
      end
    end
  end

  load_align u_align (
    .word   (word),
    .off    (req_off),
    .funct3 (req_f3),
    .result (ld)
  );

  // A combined load+store only stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data <= '0;
    end else if (commit && req_rd && !req_wr) begin
      read_data <= ld;
    end
  end

endmodule
